// File: rtl/regfile_mp_if.sv
// Bundle of the register-file read, write and reservation signals.
// The issue/writeback side uses the master modport; the register file uses slave.
interface regfile_mp_if #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 64,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1
);
    localparam int AW = $clog2(NUM_REGS);

    logic [NUM_RD*AW-1:0]     rs_addr;
    logic [NUM_RD*DATA_W-1:0] rdata;
    logic [NUM_RD-1:0]        rs_busy;
    logic [NUM_WR-1:0]        wen;
    logic [NUM_WR*AW-1:0]     waddr;
    logic [NUM_WR*DATA_W-1:0] wdata;
    logic                     rsv_en;
    logic [AW-1:0]            rsv_addr;
    logic                     rsv_waw;
    logic [NUM_REGS-1:0]      busy_vec;

    modport master (
        output rs_addr, wen, waddr, wdata, rsv_en, rsv_addr,
        input  rdata, rs_busy, rsv_waw, busy_vec
    );

    modport slave (
        input  rs_addr, wen, waddr, wdata, rsv_en, rsv_addr,
        output rdata, rs_busy, rsv_waw, busy_vec
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port integer register file with x0 hard-wired to zero, optional
// write-to-read bypass and a per-register busy scoreboard for hazard tracking.
module regfile_mp #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 64,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int BYPASS   = 1
) (
    input  logic          clk,
    input  logic          rst,
    regfile_mp_if.slave   bus
);
    localparam int AW = $clog2(NUM_REGS);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    logic [AW-1:0]            wa;
    logic [AW-1:0]            ra;
    logic [DATA_W-1:0]        rd;
    logic [NUM_RD*DATA_W-1:0] rdata_c;
    logic [NUM_RD-1:0]        rs_busy_c;

    // Ascending port order lets the highest-indexed writer win on a collision.
    always_comb begin
        wa = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            regs_d[k] = regs_q[k];
        end
        busy_d = busy_q;
        for (int j = 0; j < NUM_WR; j++) begin
            wa = bus.waddr[j*AW +: AW];
            if (bus.wen[j] && (wa != '0)) begin
                regs_d[wa] = bus.wdata[j*DATA_W +: DATA_W];
                busy_d[wa] = 1'b0;
            end
        end
        // A reservation applied after the write clear: the new producer owns the register.
        if (bus.rsv_en && (bus.rsv_addr != '0)) begin
            busy_d[bus.rsv_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= regs_d[k];
            end
            busy_q <= busy_d;
        end
    end

    always_comb begin
        ra        = '0;
        rd        = '0;
        rdata_c   = '0;
        rs_busy_c = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra = bus.rs_addr[i*AW +: AW];
            rd = regs_q[ra];
            if ((BYPASS != 0) && !rst) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (bus.wen[j] && (bus.waddr[j*AW +: AW] == ra)) begin
                        rd = bus.wdata[j*DATA_W +: DATA_W];
                    end
                end
            end
            if (ra == '0) begin
                rd = '0;
            end
            rdata_c[i*DATA_W +: DATA_W] = rd;
            rs_busy_c[i]                = busy_q[ra];
        end
    end

    assign bus.rdata    = rdata_c;
    assign bus.rs_busy  = rs_busy_c;
    assign bus.rsv_waw  = bus.rsv_en && busy_q[bus.rsv_addr] && (bus.rsv_addr != '0);
    assign bus.busy_vec = busy_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: a vector table on a two-write-port bypassing instance and a
// short hand sequence on a single-write-port non-bypassing instance.
module tb_regfile_mp;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    regfile_mp_if #(.NUM_REGS(32), .DATA_W(64), .NUM_RD(2), .NUM_WR(2)) bus_a ();
    regfile_mp_if #(.NUM_REGS(32), .DATA_W(64), .NUM_RD(2), .NUM_WR(1)) bus_b ();

    regfile_mp #(.NUM_REGS(32), .DATA_W(64), .NUM_RD(2), .NUM_WR(2), .BYPASS(1)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a.slave)
    );

    regfile_mp #(.NUM_REGS(32), .DATA_W(64), .NUM_RD(2), .NUM_WR(1), .BYPASS(0)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b.slave)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  wen;
        logic [4:0]  wa0;
        logic [63:0] wd0;
        logic [4:0]  wa1;
        logic [63:0] wd1;
        logic        rsv_en;
        logic [4:0]  rsv_a;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [63:0] e_rd0;
        logic [63:0] e_rd1;
        logic [1:0]  e_busy;
        logic        e_waw;
        logic [31:0] e_bvec;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [63:0] P = 64'h1234_5678_9ABC_DEF0;

    initial begin
        //          rst   wen    wa0   wd0                     wa1   wd1     rsv   rsv_a  ra0   ra1    e_rd0       e_rd1   e_busy e_waw e_bvec
        vecs[0]  = '{1'b0, 2'b00, 5'd0, 64'h0,                  5'd0, 64'h0,  1'b0, 5'd0,  5'd0, 5'd5,  64'h0,      64'h0,  2'b00, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 2'b01, 5'd5, 64'hDEAD,               5'd0, 64'h0,  1'b0, 5'd0,  5'd5, 5'd5,  64'hDEAD,   64'hDEAD, 2'b00, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 2'b00, 5'd0, 64'h0,                  5'd0, 64'h0,  1'b0, 5'd0,  5'd5, 5'd0,  64'hDEAD,   64'h0,  2'b00, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 2'b00, 5'd0, 64'h0,                  5'd0, 64'h0,  1'b0, 5'd0,  5'd5, 5'd0,  64'h0,      64'h0,  2'b00, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 2'b01, 5'd3, P,                      5'd0, 64'h0,  1'b0, 5'd0,  5'd3, 5'd3,  P,          P,      2'b00, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, 2'b00, 5'd0, 64'h0,                  5'd0, 64'h0,  1'b0, 5'd0,  5'd3, 5'd0,  P,          64'h0,  2'b00, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 2'b01, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 64'h0, 1'b1, 5'd0,  5'd0, 5'd0,  64'h0,      64'h0,  2'b00, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 2'b00, 5'd0, 64'h0,                  5'd0, 64'h0,  1'b0, 5'd0,  5'd0, 5'd3,  64'h0,      P,      2'b00, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 2'b11, 5'd7, 64'h11,                 5'd7, 64'h22, 1'b0, 5'd0,  5'd7, 5'd3,  64'h22,     P,      2'b00, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 2'b00, 5'd0, 64'h0,                  5'd0, 64'h0,  1'b0, 5'd0,  5'd7, 5'd7,  64'h22,     64'h22, 2'b00, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 2'b00, 5'd0, 64'h0,                  5'd0, 64'h0,  1'b1, 5'd9,  5'd9, 5'd0,  64'h0,      64'h0,  2'b00, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 2'b00, 5'd0, 64'h0,                  5'd0, 64'h0,  1'b1, 5'd9,  5'd9, 5'd0,  64'h0,      64'h0,  2'b01, 1'b1, 32'h200};
        vecs[12] = '{1'b0, 2'b01, 5'd9, 64'hAB,                 5'd0, 64'h0,  1'b1, 5'd9,  5'd9, 5'd9,  64'hAB,     64'hAB, 2'b11, 1'b1, 32'h200};
        vecs[13] = '{1'b0, 2'b01, 5'd9, 64'hCD,                 5'd0, 64'h0,  1'b0, 5'd0,  5'd9, 5'd0,  64'hCD,     64'h0,  2'b01, 1'b0, 32'h200};
        vecs[14] = '{1'b0, 2'b01, 5'd6, 64'h99,                 5'd0, 64'h0,  1'b1, 5'd10, 5'd9, 5'd6,  64'hCD,     64'h99, 2'b00, 1'b0, 32'h0};
        vecs[15] = '{1'b1, 2'b01, 5'd6, 64'h55,                 5'd0, 64'h0,  1'b1, 5'd4,  5'd6, 5'd4,  64'h99,     64'h0,  2'b00, 1'b0, 32'h400};
        vecs[16] = '{1'b0, 2'b00, 5'd0, 64'h0,                  5'd0, 64'h0,  1'b0, 5'd0,  5'd6, 5'd4,  64'h0,      64'h0,  2'b00, 1'b0, 32'h0};

        rst_a          = 1'b1;
        rst_b          = 1'b1;
        bus_a.wen      = '0;
        bus_a.waddr    = '0;
        bus_a.wdata    = '0;
        bus_a.rs_addr  = '0;
        bus_a.rsv_en   = 1'b0;
        bus_a.rsv_addr = '0;
        bus_b.wen      = '0;
        bus_b.waddr    = '0;
        bus_b.wdata    = '0;
        bus_b.rs_addr  = '0;
        bus_b.rsv_en   = 1'b0;
        bus_b.rsv_addr = '0;
        tick();
        rst_b = 1'b0;

        for (int v = 0; v < NV; v++) begin
            rst_a          = vecs[v].rst;
            bus_a.wen      = vecs[v].wen;
            bus_a.waddr    = {vecs[v].wa1, vecs[v].wa0};
            bus_a.wdata    = {vecs[v].wd1, vecs[v].wd0};
            bus_a.rsv_en   = vecs[v].rsv_en;
            bus_a.rsv_addr = vecs[v].rsv_a;
            bus_a.rs_addr  = {vecs[v].ra1, vecs[v].ra0};
            #2;
            chk($sformatf("v%0d rdata0", v), bus_a.rdata[63:0], vecs[v].e_rd0);
            chk($sformatf("v%0d rdata1", v), bus_a.rdata[127:64], vecs[v].e_rd1);
            chk($sformatf("v%0d rs_busy", v), {62'b0, bus_a.rs_busy}, {62'b0, vecs[v].e_busy});
            chk($sformatf("v%0d rsv_waw", v), {63'b0, bus_a.rsv_waw}, {63'b0, vecs[v].e_waw});
            chk($sformatf("v%0d busy_vec", v), {32'b0, bus_a.busy_vec}, {32'b0, vecs[v].e_bvec});
            tick();
        end
        rst_a = 1'b0;

        // Non-bypassing instance: a write becomes visible only after its edge.
        chk("nb reset rdata", bus_b.rdata, 128'h0);
        chk("nb reset busy_vec", {32'b0, bus_b.busy_vec}, 64'h0);
        bus_b.wen     = 1'b1;
        bus_b.waddr   = 5'd3;
        bus_b.wdata   = P;
        bus_b.rs_addr = {5'd3, 5'd3};
        #2;
        chk("nb same-cycle rdata0", bus_b.rdata[63:0], 64'h0);
        chk("nb same-cycle rdata1", bus_b.rdata[127:64], 64'h0);
        tick();
        bus_b.wen = 1'b0;
        #2;
        chk("nb next-cycle rdata0", bus_b.rdata[63:0], P);
        chk("nb next-cycle rdata1", bus_b.rdata[127:64], P);
        bus_b.wen     = 1'b1;
        bus_b.waddr   = 5'd0;
        bus_b.wdata   = 64'hFFFF_FFFF_FFFF_FFFF;
        bus_b.rs_addr = {5'd3, 5'd0};
        tick();
        bus_b.wen = 1'b0;
        #2;
        chk("nb x0 after write", bus_b.rdata[63:0], 64'h0);
        chk("nb x3 held", bus_b.rdata[127:64], P);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
